// File: rtl/shift_rot_unit_pkg.sv
// Shared constants, opcode encodings and FSM state type for the shift/rotate unit.
// Every file in this unit imports this package so all of them use the same encodings.
package shift_rot_unit_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_BTR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Opcodes 101..111 all pass the operand through unchanged.
  function automatic logic is_pass(input logic [2:0] op);
    return op > OP_BTR;
  endfunction

endpackage

// File: rtl/shift_rot_unit_btr.sv
// Purely combinational 16-bit bit reversal: Out[i] = In[15-i].
module shift_rot_unit_btr
  import shift_rot_unit_pkg::*;
(
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Out
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign Out[gi] = In[WIDTH-1-gi];
  end

endmodule

// File: rtl/shift_rot_unit.sv
// Iterative one-bit-per-cycle shift/rotate unit with a valid/ready handshake on both
// sides; BTR and PASS finish in a single cycle and the result register holds under stall.
module shift_rot_unit
  import shift_rot_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  state_e           r_state;
  state_e           w_state_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_btr;
  logic [WIDTH-1:0] w_step;
  logic             w_direct;
  logic             w_last;

  shift_rot_unit_btr u_btr (
    .In  (in_a),
    .Out (w_btr)
  );

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;

  // Ops that need no iteration complete straight from IDLE.
  assign w_direct = (in_op == OP_BTR) || is_pass(in_op) || (in_amt == '0);
  assign w_last   = (r_cnt == AMT_W'(1));

  always_comb begin
    w_step = r_work;
    case (r_op)
      OP_ROL:  w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
      OP_ROR:  w_step = {r_work[0], r_work[WIDTH-1:1]};
      OP_SRA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_step = r_work;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (in_valid) w_state_next = w_direct ? ST_DONE : ST_SHIFT;
        ST_SHIFT: if (w_last) w_state_next = ST_DONE;
        ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      // A flush leaves the datapath untouched; only the state returns to IDLE.
      if (!flush) begin
        case (r_state)
          ST_IDLE: begin
            if (in_valid) begin
              r_op   <= in_op;
              r_cnt  <= in_amt;
              r_work <= in_a;
              if (in_op == OP_BTR) r_result <= w_btr;
              else if (w_direct)   r_result <= in_a;
            end
          end
          ST_SHIFT: begin
            r_work <= w_step;
            r_cnt  <= r_cnt - AMT_W'(1);
            if (w_last) r_result <= w_step;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_rot_unit.sv
// Randomized and directed bench for shift_rot_unit against an arithmetic reference model.
module tb_shift_rot_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [15:0] in_a = 16'd0;
  logic [3:0]  in_amt = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;

  int n_cmp = 0;
  int n_bad = 0;

  shift_rot_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_amt     (in_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_model(input logic [2:0] op, input logic [15:0] a, input int amt);
    logic [15:0] r;
    case (op)
      3'd0: r = (a << amt) | (a >> (16 - amt));
      3'd1: r = a << amt;
      3'd2: r = (a >> amt) | (a << (16 - amt));
      3'd3: r = 16'($signed(a) >>> amt);
      3'd4: r = {<<{a}};
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input int amt);
    return (op >= 3'd4 || amt == 0) ? 1 : amt + 1;
  endfunction

  // Starts and ends at a negedge; next op may be issued immediately after return.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [3:0] amt, input int hold);
    logic [15:0] exp_res;
    int          exp_lat;
    int          lat;
    bit          busy_ok;
    exp_res = ref_model(op, a, int'(amt));
    exp_lat = ref_latency(op, int'(amt));
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_amt = amt;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_op = 3'($urandom); in_a = 16'($urandom); in_amt = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("result", {16'd0, out_result}, {16'd0, exp_res});
    chk("busy_ready", {31'd0, busy_ok}, 32'd1);
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_op = 3'($urandom); in_a = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", {16'd0, out_result}, {16'd0, exp_res});
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("consumed_valid", {31'd0, out_valid}, 32'd0);
    chk("consumed_ready", {31'd0, in_ready}, 32'd1);
    $display("op=%0d a=%h amt=%0d hold=%0d -> result=%h (exp %h) lat=%0d (exp %0d)",
             op, a, amt, hold, out_result, exp_res, lat, exp_lat);
  endtask

  // ROR 0x0001 by 8, aborted three cycles into SHIFT by flush or by reset.
  task automatic abort_test(input bit use_reset);
    bit seen;
    in_valid = 1'b1; in_op = 3'd2; in_a = 16'h0001; in_amt = 4'd8;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    if (use_reset) rst_n = 1'b0;
    else flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    chk(use_reset ? "rst_ready" : "flush_ready", {31'd0, in_ready}, 32'd1);
    chk(use_reset ? "rst_valid" : "flush_valid", {31'd0, out_valid}, 32'd0);
    if (use_reset) chk("rst_result", {16'd0, out_result}, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk(use_reset ? "rst_no_valid" : "flush_no_valid", {31'd0, seen}, 32'd0);
    $display("abort via %s mid-SHIFT: out_valid seen=%0d", use_reset ? "reset" : "flush", seen);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_result", {16'd0, out_result}, 32'd0);

    run_op(3'd4, 16'h0001, 4'd0, 0);
    run_op(3'd0, 16'h8001, 4'd4, 0);
    run_op(3'd3, 16'h8000, 4'd15, 0);
    run_op(3'd1, 16'h1234, 4'd0, 0);
    run_op(3'd2, 16'h0001, 4'd8, 3);
    run_op(3'd7, 16'hBEEF, 4'd9, 0);

    abort_test(1'b0);
    abort_test(1'b1);

    // flush with in_valid in IDLE must not accept
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd5; in_a = 16'h5555;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);
    $display("flush+in_valid in IDLE: in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // flush drops a held result
    in_valid = 1'b1; in_op = 3'd6; in_a = 16'hAAAA; in_amt = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_done_ready", {31'd0, in_ready}, 32'd1);
    $display("flush in DONE: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom), 16'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
